// File: rtl/alu_result_spi_tx_if.sv
// alu_result_spi_tx_if: valid/ready load port carrying an ALU result word and its NZCV flags
interface alu_result_spi_tx_if #(
    parameter int WIDTH = 4
);
    logic [2*WIDTH-1:0] result;
    logic [3:0]         flags;
    logic               load_valid;
    logic               load_ready;
    modport master (output result, flags, load_valid, input load_ready);
    modport slave  (input result, flags, load_valid, output load_ready);
endinterface

// File: rtl/alu_result_spi_tx.sv
// alu_result_spi_tx: SPI mode-0 slave transmitter of {NZCV, result} frames, MSB first
// Define ALU_TX_PARITY_EN to append an even-parity bit to every frame.
module alu_result_spi_tx #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_spi_tx_if.slave ld,
    input  logic               sclk,
    input  logic               cs_n,
    output logic               miso,
    output logic               miso_oe,
    output logic               busy,
    output logic               done,
    output logic               underrun,
    output logic               abort
);
    localparam int DW = 2*WIDTH+4;
`ifdef ALU_TX_PARITY_EN
    localparam int FRAME_LEN = DW+1;
`else
    localparam int FRAME_LEN = DW;
`endif
    localparam int CW = $clog2(FRAME_LEN+1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t               state;
    logic [2:0]           sclk_s, cs_s;
    logic [DW-1:0]        hold;
    logic                 hold_valid;
    logic [FRAME_LEN-1:0] sh, frame;
    logic [CW-1:0]        cnt;
    logic                 sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
`ifdef ALU_TX_PARITY_EN
    assign frame = {hold, ^hold};
`else
    assign frame = hold;
`endif
    assign ld.load_ready = !hold_valid;
    assign busy    = state == SHIFT;
    assign miso    = busy & sh[FRAME_LEN-1];
    assign miso_oe = !cs_s[1];
    // cs_n synchroniser resets high so the pins read as deselected during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s     <= '0;
            cs_s       <= '1;
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            sh         <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            abort      <= 1'b0;
        end else begin
            sclk_s   <= {sclk_s[1:0], sclk};
            cs_s     <= {cs_s[1:0], cs_n};
            done     <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
            if (ld.load_valid && !hold_valid) begin
                hold       <= {ld.flags, ld.result};
                hold_valid <= 1'b1;
            end
            case (state)
                IDLE: if (cs_fall) begin
                    state <= SHIFT;
                    cnt   <= '0;
                    sh    <= hold_valid ? frame : '0;
                    if (hold_valid) hold_valid <= 1'b0;
                    else underrun <= 1'b1;
                end
                SHIFT: if (cs_rise) begin
                    state <= IDLE;
                    done  <= cnt == LAST;
                    abort <= cnt != LAST;
                end else begin
                    if (sclk_rise && cnt != LAST) cnt <= cnt + 1'b1;
                    if (sclk_fall) sh <= sh << 1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_spi_tx.sv
// tb_alu_result_spi_tx: directed table-driven bench for the ALU result SPI transmitter
module tb_alu_result_spi_tx;
    localparam int W = 4;
`ifdef ALU_TX_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif
    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1;
    logic miso, miso_oe, busy, done, underrun, abort;
    logic [15:0] rx;
    int errors = 0, checks = 0, n_done = 0, n_under = 0, n_abort = 0;
    int d0, a0, u0;

    alu_result_spi_tx_if #(.WIDTH(W)) ld_if ();
    alu_result_spi_tx #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ld(ld_if), .sclk(sclk), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe), .busy(busy), .done(done),
        .underrun(underrun), .abort(abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) n_done++;
        if (underrun) n_under++;
        if (abort) n_abort++;
    end

    typedef struct {
        logic        pre;
        logic [7:0]  res;
        logic [3:0]  flg;
        int          nb;
        logic [15:0] exp_rx;
        int          e_done, e_abort, e_under;
    } vec_t;
    vec_t v [8];

    function automatic logic [15:0] ef(input logic [11:0] val, input logic p);
        return (FL == 13) ? {3'b0, val, p} : {4'b0, val};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] r, input logic [3:0] f);
        @(negedge clk);
        ld_if.result = r;
        ld_if.flags = f;
        ld_if.load_valid = 1'b1;
        @(negedge clk);
        ld_if.load_valid = 1'b0;
    endtask

    task automatic cs_start();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic clock_bits(input int nbits, output logic [15:0] r);
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            r = {r[14:0], miso};
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic snap();
        d0 = n_done;
        a0 = n_abort;
        u0 = n_under;
    endtask

    initial begin
        ld_if.result = '0;
        ld_if.flags = '0;
        ld_if.load_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ld_if.load_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        v[0] = '{1'b1, 8'hA5, 4'b0010, FL,     ef(12'h2A5, 1'b1),      1, 0, 0};
        v[1] = '{1'b0, 8'h00, 4'b0000, FL,     16'h0000,               1, 0, 1};
        v[2] = '{1'b1, 8'hFF, 4'b1111, FL,     ef(12'hFFF, 1'b0),      1, 0, 0};
        v[3] = '{1'b1, 8'h01, 4'b1000, FL,     ef(12'h801, 1'b0),      1, 0, 0};
        v[4] = '{1'b1, 8'h3C, 4'b0101, FL + 2, ef(12'h53C, 1'b0) << 2, 1, 0, 0};
        v[5] = '{1'b1, 8'h96, 4'b1100, 5,      16'h0019,               0, 1, 0};
        v[6] = '{1'b1, 8'h5A, 4'b0011, FL,     ef(12'h35A, 1'b0),      1, 0, 0};
        v[7] = '{1'b1, 8'hA5, 4'b0010, 12,     16'h02A5, int'(FL == 12), int'(FL == 13), 0};

        for (int i = 0; i < 8; i++) begin
            if (v[i].pre) load(v[i].res, v[i].flg);
            snap();
            cs_start();
            chk($sformatf("v%0d_ready", i), ld_if.load_ready, 1);
            chk($sformatf("v%0d_oe", i), miso_oe, 1);
            clock_bits(v[i].nb, rx);
            cs_end();
            chk($sformatf("v%0d_rx", i), rx, v[i].exp_rx);
            chk($sformatf("v%0d_done", i), 16'(n_done - d0), 16'(v[i].e_done));
            chk($sformatf("v%0d_abort", i), 16'(n_abort - a0), 16'(v[i].e_abort));
            chk($sformatf("v%0d_under", i), 16'(n_under - u0), 16'(v[i].e_under));
        end

        // load during a frame, then a blocked third load while hold is full
        load(8'hA5, 4'b0010);
        cs_start();
        load(8'h3C, 4'b0101);
        chk("q_ready_full", ld_if.load_ready, 0);
        @(negedge clk);
        ld_if.result = 8'hFF;
        ld_if.flags = 4'hF;
        ld_if.load_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("q_third_blocked", ld_if.load_ready, 0);
        ld_if.load_valid = 1'b0;
        clock_bits(FL, rx);
        cs_end();
        chk("q_rx1", rx, ef(12'h2A5, 1'b1));
        cs_start();
        clock_bits(FL, rx);
        cs_end();
        chk("q_rx2", rx, ef(12'h53C, 1'b0));

        // load coinciding with the synchronised cs_n fall while hold is empty
        snap();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        ld_if.result = 8'h77;
        ld_if.flags = 4'b1001;
        ld_if.load_valid = 1'b1;
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        repeat (5) @(negedge clk);
        clock_bits(FL, rx);
        cs_end();
        chk("c_rx", rx, 16'h0000);
        chk("c_under", 16'(n_under - u0), 16'd1);
        chk("c_held", ld_if.load_ready, 0);
        cs_start();
        clock_bits(FL, rx);
        cs_end();
        chk("c_rx_next", rx, ef(12'h977, 1'b0));

        // reset in the middle of a frame
        load(8'hA5, 4'b0010);
        cs_start();
        clock_bits(3, rx);
        chk("r_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_miso", miso, 0);
        chk("r_oe", miso_oe, 0);
        chk("r_pulses", {done, underrun, abort}, 0);
        chk("r_ready", ld_if.load_ready, 1);
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        snap();
        cs_start();
        clock_bits(FL, rx);
        cs_end();
        chk("r_rx", rx, 16'h0000);
        chk("r_under", 16'(n_under - u0), 16'd1);
        chk("r_done", 16'(n_done - d0), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
